// File: rtl/osnt_gen_pkg.sv
// Shared definitions for the generator pipeline: rate-limiter FSM states and
// the guard bits that size the signed token counter.
package osnt_gen_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      IN_PKT = 1'b1
   } rl_state_e;

   // Two extra bits keep worst-case deficit plus full bucket representable.
   localparam int TOKEN_GUARD_W = 2;

   function automatic int token_w(input int cfg_w);
      return cfg_w + TOKEN_GUARD_W;
   endfunction

endpackage

// File: rtl/packet_rate_limiter_popcount.sv
// Combinational byte counter: number of set strobe bits on a stream beat.
module strb_popcount #(
   parameter int STRB_W = 32,
   parameter int CNT_W  = $clog2(STRB_W + 1)
) (
   input  logic [STRB_W-1:0] strb_i,
   output logic [CNT_W-1:0]  cnt_o
);

   always_comb begin
      cnt_o = '0;
      for (int i = 0; i < STRB_W; i++) cnt_o = cnt_o + CNT_W'(strb_i[i]);
   end

endmodule

// File: rtl/packet_rate_limiter.sv
// Token-bucket packet rate limiter: zero-latency pass-through stream gated at
// packet boundaries by a signed byte credit that may run into deficit.
module packet_rate_limiter
   import osnt_gen_pkg::*;
#(
   parameter int C_M_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int C_S_AXI_DATA_WIDTH   = 32
) (
   input  logic                                axi_aclk,
   input  logic                                axi_aresetn,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
   input  logic                                s_axis_tvalid,
   input  logic                                s_axis_tlast,
   output logic                                s_axis_tready,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
   output logic                                m_axis_tvalid,
   output logic                                m_axis_tlast,
   input  logic                                m_axis_tready,
   input  logic                                sw_rst,
   input  logic                                rl_en,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]       token_inc,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]       bucket_max,
   output logic [C_S_AXI_DATA_WIDTH+1:0]       tokens
);

   localparam int TOKEN_W = token_w(C_S_AXI_DATA_WIDTH);
   localparam int STRB_W  = C_S_AXIS_DATA_WIDTH / 8;
   localparam int CNT_W   = $clog2(STRB_W + 1);
   localparam int SUM_W   = TOKEN_W + 1;

   rl_state_e                 state_q, state_d;
   logic signed [TOKEN_W-1:0] tokens_q, tokens_d;
   logic                      allow, accept;
   logic [CNT_W-1:0]          beat_bytes, debit;
   logic signed [SUM_W-1:0]   sum, cap;
   logic                      unused_inc_hi;

   assign m_axis_tdata  = s_axis_tdata;
   assign m_axis_tstrb  = s_axis_tstrb;
   assign m_axis_tuser  = s_axis_tuser;
   assign m_axis_tlast  = s_axis_tlast;
   assign tokens        = tokens_q;
   assign unused_inc_hi = ^token_inc[C_S_AXI_DATA_WIDTH-1:16];

   strb_popcount #(.STRB_W(STRB_W), .CNT_W(CNT_W)) u_popcnt (
      .strb_i (s_axis_tstrb),
      .cnt_o  (beat_bytes)
   );

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state_q  <= IDLE;
         tokens_q <= '0;
      end else begin
         state_q  <= state_d;
         tokens_q <= tokens_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (sw_rst)      state_d = IDLE;
      else if (accept) state_d = s_axis_tlast ? IDLE : IN_PKT;
   end

   // Credit is only consulted at a first beat; an open packet always flows.
   always_comb begin
      allow         = !rl_en || (state_q == IN_PKT) || !tokens_q[TOKEN_W-1];
      m_axis_tvalid = s_axis_tvalid & allow;
      s_axis_tready = m_axis_tready & allow;
   end

   assign accept = s_axis_tvalid & s_axis_tready;
   assign debit  = accept ? beat_bytes : '0;
   assign cap    = $signed({{(SUM_W-C_S_AXI_DATA_WIDTH){1'b0}}, bucket_max});
   assign sum    = $signed({tokens_q[TOKEN_W-1], tokens_q})
                 + $signed({{(SUM_W-16){1'b0}}, token_inc[15:0]})
                 - $signed({{(SUM_W-CNT_W){1'b0}}, debit});

   always_comb begin
      tokens_d = tokens_q;
      if (sw_rst)         tokens_d = '0;
      else if (!rl_en)    tokens_d = cap[TOKEN_W-1:0];
      else if (sum > cap) tokens_d = cap[TOKEN_W-1:0];
      else                tokens_d = sum[TOKEN_W-1:0];
   end

endmodule
